oc8051_ext_fetch: RTL

//   Instruction fetch unit for external program memory. It sits directly upstream of the

---
 rtl/oc8051_ext_fetch_if.sv | 11 +
 rtl/oc8051_ext_fetch.sv | 119 +++++++++++
 2 files changed

// File: rtl/oc8051_ext_fetch_if.sv
// Wishbone-style 32-bit read bus between the external fetch unit and program memory.
interface oc8051_ext_fetch_if;
  logic [15:0] wbi_adr_o;
  logic        wbi_stb_o;
  logic        wbi_cyc_o;
  logic [31:0] wbi_dat_i;
  logic        wbi_ack_i;

  modport master (output wbi_adr_o, wbi_stb_o, wbi_cyc_o, input wbi_dat_i, wbi_ack_i);
  modport slave  (input wbi_adr_o, wbi_stb_o, wbi_cyc_o, output wbi_dat_i, wbi_ack_i);
endinterface

// File: rtl/oc8051_ext_fetch.sv
// External program-memory fetch unit: two-word line buffer presenting bytes PC..PC+2,
// refilled over a 32-bit read bus with optional next-word prefetch.
module oc8051_ext_fetch #(
  parameter int unsigned PREFETCH = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pc_i,
  input  logic        istb_i,
  output logic        iack_o,
  output logic [7:0]  op1_o,
  output logic [7:0]  op2_o,
  output logic [7:0]  op3_o,
  oc8051_ext_fetch_if.master wbi
);

  typedef enum logic [1:0] {IDLE, FILL0, FILL1, PREF} state_t;

  state_t      state_q;
  logic [31:0] word0_q;
  logic [31:0] word1_q;
  logic [13:0] tag_q;
  logic        v0_q;
  logic        v1_q;
  logic        stb_q;
  logic [13:0] adr_q;

  logic [13:0] pc_word;
  logic [13:0] tag_inc;
  logic        tag_match;
  logic        hit;
  logic        slide;
  logic [63:0] line_sh;

  assign pc_word   = pc_i[15:2];
  assign tag_inc   = tag_q + 14'd1;
  assign tag_match = (pc_word == tag_q);
  // Offsets 0 and 1 fit entirely in word0; offsets 2 and 3 spill into word1.
  assign hit       = tag_match & v0_q & (~pc_i[1] | v1_q);
  assign slide     = (pc_word == tag_inc) & v1_q;

  assign line_sh = {word1_q, word0_q} >> {pc_i[1:0], 3'b000};

  assign iack_o = istb_i & hit;
  assign op1_o  = iack_o ? line_sh[7:0]   : 8'h00;
  assign op2_o  = iack_o ? line_sh[15:8]  : 8'h00;
  assign op3_o  = iack_o ? line_sh[23:16] : 8'h00;

  assign wbi.wbi_adr_o = {adr_q, 2'b00};
  assign wbi.wbi_stb_o = stb_q;
  assign wbi.wbi_cyc_o = stb_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      word0_q <= '0;
      word1_q <= '0;
      tag_q   <= '0;
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
      stb_q   <= 1'b0;
      adr_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (istb_i && !hit) begin
            if (slide) begin
              word0_q <= word1_q;
              tag_q   <= tag_inc;
              v1_q    <= 1'b0;
            end else if (tag_match && v0_q) begin
              state_q <= FILL1;
              adr_q   <= tag_inc;
              stb_q   <= 1'b1;
            end else begin
              tag_q   <= pc_word;
              v0_q    <= 1'b0;
              v1_q    <= 1'b0;
              state_q <= FILL0;
              adr_q   <= pc_word;
              stb_q   <= 1'b1;
            end
          end else if ((PREFETCH != 0) && v0_q && !v1_q) begin
            state_q <= PREF;
            adr_q   <= tag_inc;
            stb_q   <= 1'b1;
          end
        end
        FILL0: begin
          if (wbi.wbi_ack_i) begin
            word0_q <= wbi.wbi_dat_i;
            v0_q    <= 1'b1;
            // Chain straight into the second word when the current PC still needs it.
            if (tag_match && pc_i[1]) begin
              state_q <= FILL1;
              adr_q   <= tag_inc;
            end else begin
              state_q <= IDLE;
              stb_q   <= 1'b0;
            end
          end
        end
        FILL1, PREF: begin
          if (wbi.wbi_ack_i) begin
            word1_q <= wbi.wbi_dat_i;
            v1_q    <= 1'b1;
            state_q <= IDLE;
            stb_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          stb_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule
